// File: rtl/rs232_rx_fifo_if.sv
// Receive-FIFO bus: receiver handshake on one side, CPU IO read/status on the other.
interface rs232_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      rx_data;
    logic            rx_rdy;
    logic            rx_done;
    logic            pop;
    logic [7:0]      dout;
    logic            rdy;
    logic            full;
    logic [ADDR_W:0] count;
    logic            ovf;
    logic [7:0]      drops;
    logic            ovf_clr;

    modport slave (
        input  rx_data, rx_rdy, pop, ovf_clr,
        output rx_done, dout, rdy, full, count, ovf, drops
    );

    modport master (
        output rx_data, rx_rdy, pop, ovf_clr,
        input  rx_done, dout, rdy, full, count, ovf, drops
    );
endinterface

// File: rtl/rs232_rx_fifo.sv
// RS-232 receive buffer: drains receiver bytes into a first-word-fall-through FIFO
// with a sticky overflow flag and a saturating dropped-byte counter.
module rs232_rx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rs232_rx_fifo_if.slave       bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    state_t            r_state;
    logic              r_rx_done;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic [7:0]        r_drops;

    logic w_empty;
    logic w_full;
    logic w_push_req;
    logic w_push_ok;
    logic w_drop;
    logic w_pop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == L_DEPTH);
    assign w_push_req = (r_state == S_IDLE) && bus.rx_rdy;
    // A full FIFO still accepts when the CPU frees a slot in the same cycle.
    assign w_push_ok  = w_push_req && (!w_full || bus.pop);
    assign w_drop     = w_push_req && !w_push_ok;
    assign w_pop      = bus.pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rx_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_rdy) begin
                        r_state   <= S_ACK;
                        r_rx_done <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state   <= S_WAIT;
                    r_rx_done <= 1'b0;
                end
                S_WAIT: begin
                    if (!bus.rx_rdy) r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_rx_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop coinciding with a clear restarts the tally at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf   <= 1'b0;
            r_drops <= '0;
        end else if (w_drop) begin
            r_ovf   <= 1'b1;
            r_drops <= bus.ovf_clr ? 8'd1 : sat_inc(r_drops);
        end else if (bus.ovf_clr) begin
            r_ovf   <= 1'b0;
            r_drops <= '0;
        end
    end

    assign bus.rx_done = r_rx_done;
    assign bus.dout    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.rdy     = !w_empty;
    assign bus.full    = w_full;
    assign bus.count   = r_count;
    assign bus.ovf     = r_ovf;
    assign bus.drops   = r_drops;
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed bench for rs232_rx_fifo: capture handshake, FIFO order, wrap, overflow and reset.
module tb_rs232_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   pulses;
    logic [7:0] wv;
    logic [7:0] rv;

    rs232_rx_fifo_if #(.ADDR_W(4)) bus ();

    rs232_rx_fifo #(.ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Receiver model: hold rx_rdy until the acknowledge, then release.
    task automatic send(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (bus.rx_done === 1'b1) seen = 1'b1;
        end
        chk("ack_seen", {31'd0, seen}, 32'd1);
        bus.rx_rdy = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        bus.pop = 1'b1;
        chk("pop_dout", {24'd0, bus.dout}, {24'd0, exp});
        tick();
        bus.pop = 1'b0;
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_rdy  = 1'b0;
        bus.pop     = 1'b0;
        bus.ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_rdy",     {31'd0, bus.rdy},     32'd0);
        chk("rst_count",   {27'd0, bus.count},   32'd0);
        chk("rst_full",    {31'd0, bus.full},    32'd0);
        chk("rst_ovf",     {31'd0, bus.ovf},     32'd0);
        chk("rst_drops",   {24'd0, bus.drops},   32'd0);
        chk("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
        chk("rst_dout",    {24'd0, bus.dout},    32'd0);

        // Single byte with exactly one acknowledge pulse
        bus.rx_data = 8'h41;
        bus.rx_rdy  = 1'b1;
        tick();
        chk("one_done_hi", {31'd0, bus.rx_done}, 32'd1);
        bus.rx_rdy = 1'b0;
        tick();
        chk("one_done_lo1", {31'd0, bus.rx_done}, 32'd0);
        tick();
        chk("one_done_lo2", {31'd0, bus.rx_done}, 32'd0);
        chk("one_rdy",   {31'd0, bus.rdy},   32'd1);
        chk("one_count", {27'd0, bus.count}, 32'd1);
        pop_chk(8'h41);
        chk("one_count0", {27'd0, bus.count}, 32'd0);
        chk("one_rdy0",   {31'd0, bus.rdy},   32'd0);
        chk("one_dout0",  {24'd0, bus.dout},  32'd0);

        // Pop on empty is ignored
        pop_chk(8'h00);
        chk("empty_pop_count", {27'd0, bus.count}, 32'd0);

        // Fill 16, then overflow byte
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("fill_full",  {31'd0, bus.full},  32'd1);
        chk("fill_count", {27'd0, bus.count}, 32'd16);
        chk("fill_ovf",   {31'd0, bus.ovf},   32'd0);
        send(8'hAA);
        chk("ovf_flag",  {31'd0, bus.ovf},   32'd1);
        chk("ovf_drops", {24'd0, bus.drops}, 32'd1);
        chk("ovf_count", {27'd0, bus.count}, 32'd16);
        for (int i = 0; i < 16; i++) pop_chk(8'(i));
        chk("drain_count", {27'd0, bus.count}, 32'd0);

        // Full FIFO, push coincides with pop
        do_reset();
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        bus.rx_data = 8'hBB;
        bus.rx_rdy  = 1'b1;
        bus.pop     = 1'b1;
        chk("pp_dout", {24'd0, bus.dout}, 32'h10);
        tick();
        bus.pop = 1'b0;
        chk("pp_done",  {31'd0, bus.rx_done}, 32'd1);
        chk("pp_count", {27'd0, bus.count},   32'd16);
        chk("pp_ovf",   {31'd0, bus.ovf},     32'd0);
        bus.rx_rdy = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 16; i++) pop_chk(8'h10 + 8'(i));
        pop_chk(8'hBB);
        chk("pp_count0", {27'd0, bus.count}, 32'd0);

        // Receiver slow to clear rx_rdy
        do_reset();
        bus.rx_data = 8'h55;
        bus.rx_rdy  = 1'b1;
        tick();
        chk("slow_done", {31'd0, bus.rx_done}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rx_done === 1'b1) pulses++;
        end
        chk("slow_extra_done", pulses, 32'd0);
        bus.rx_rdy = 1'b0;
        tick();
        tick();
        chk("slow_count", {27'd0, bus.count}, 32'd1);
        chk("slow_dout",  {24'd0, bus.dout},  32'h55);

        // Pointer wrap: fill 10, pop 8, fill 10, pop 12
        do_reset();
        wv = 8'h00;
        rv = 8'h00;
        for (int i = 0; i < 10; i++) begin send(wv); wv++; end
        for (int i = 0; i < 8; i++)  begin pop_chk(rv); rv++; end
        for (int i = 0; i < 10; i++) begin send(wv); wv++; end
        chk("wrap_count_mid", {27'd0, bus.count}, 32'd12);
        for (int i = 0; i < 12; i++) begin pop_chk(rv); rv++; end
        chk("wrap_count0", {27'd0, bus.count}, 32'd0);
        chk("wrap_rdy0",   {31'd0, bus.rdy},   32'd0);

        // Saturating drop counter
        do_reset();
        for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i));
        for (int i = 0; i < 300; i++) send(8'hEE);
        chk("sat_drops", {24'd0, bus.drops}, 32'd255);
        chk("sat_ovf",   {31'd0, bus.ovf},   32'd1);
        chk("sat_count", {27'd0, bus.count}, 32'd16);
        chk("sat_head",  {24'd0, bus.dout},  32'hC0);

        // Clear coincident with a drop: set wins
        bus.rx_data = 8'hEF;
        bus.rx_rdy  = 1'b1;
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("clr_drop_ovf",   {31'd0, bus.ovf},   32'd1);
        chk("clr_drop_drops", {24'd0, bus.drops}, 32'd1);
        bus.rx_rdy = 1'b0;
        tick();
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("clr_ovf",   {31'd0, bus.ovf},   32'd0);
        chk("clr_drops", {24'd0, bus.drops}, 32'd0);

        // Reset with count=5 and capture FSM in ACK
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h60 + 8'(i));
        bus.rx_data = 8'h66;
        bus.rx_rdy  = 1'b1;
        tick();
        chk("pre_rst_done",  {31'd0, bus.rx_done}, 32'd1);
        chk("pre_rst_count", {27'd0, bus.count},   32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", {27'd0, bus.count},   32'd0);
        chk("mid_rst_rdy",   {31'd0, bus.rdy},     32'd0);
        chk("mid_rst_done",  {31'd0, bus.rx_done}, 32'd0);
        chk("mid_rst_dout",  {24'd0, bus.dout},    32'd0);
        tick();
        chk("post_rst_done",  {31'd0, bus.rx_done}, 32'd1);
        chk("post_rst_count", {27'd0, bus.count},   32'd1);
        chk("post_rst_dout",  {24'd0, bus.dout},    32'h66);
        bus.rx_rdy = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
